// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the comparator arbiter:
//   - bit positions of the six result flags inside res_flags
//   - the three legal flag patterns (equal / less-than / greater-than)
//   - the arbiter FSM state encoding
//   - width of the optional result-class counters
// Imported by cmp_core and comparator_arbiter.
// -----------------------------------------------------------------------------
package cmp_pkg;

  // Flag bit positions within the 6-bit result
  localparam int FLG_EQ = 5;
  localparam int FLG_NE = 4;
  localparam int FLG_GT = 3;
  localparam int FLG_LT = 2;
  localparam int FLG_GE = 1;
  localparam int FLG_LE = 0;

  // Complete flag words for each outcome of an unsigned compare
  localparam logic [5:0] FLAGS_EQ = 6'b100011;
  localparam logic [5:0] FLAGS_LT = 6'b010101;
  localparam logic [5:0] FLAGS_GT = 6'b011010;

  // Width of the optional per-class result counters
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/cmp_core.sv
// -----------------------------------------------------------------------------
// cmp_core
// Purely combinational unsigned magnitude comparator.
// Ports:
//   a_i     in  DATA_W  operand A
//   b_i     in  DATA_W  operand B
//   flags_o out 6       {EQ, NE, GT, LT, GE, LE}
// -----------------------------------------------------------------------------
module cmp_core
  import cmp_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [5:0]        flags_o
);

  logic eq;
  logic gt;
  logic lt;

  always_comb begin
    eq = (a_i == b_i);
    gt = (a_i > b_i);
    lt = (a_i < b_i);

    flags_o         = '0;
    flags_o[FLG_EQ] = eq;
    flags_o[FLG_NE] = ~eq;
    flags_o[FLG_GT] = gt;
    flags_o[FLG_LT] = lt;
    flags_o[FLG_GE] = ~lt;
    flags_o[FLG_LE] = ~gt;
  end

endmodule

// File: rtl/comparator_arbiter.sv
// -----------------------------------------------------------------------------
// comparator_arbiter
// Shares one magnitude comparator among NUM_REQ requesters. A round-robin
// arbiter grants one requester while idle, its operands are registered, the
// compare runs in the following cycle, and the tagged result is then held
// until the consumer accepts it. At most one result every three cycles.
//
// Ports:
//   clk        in   1                clock
//   rst        in   1                synchronous reset, active-high
//   req_valid  in   NUM_REQ          per-requester operand valid
//   req_ready  out  NUM_REQ          grant / accept, one-hot or zero
//   req_a      in   NUM_REQ*DATA_W   operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b      in   NUM_REQ*DATA_W   operand B, same packing
//   res_valid  out  1                result valid
//   res_ready  in   1                consumer accepts result
//   res_flags  out  6                {EQ, NE, GT, LT, GE, LE}
//   res_id     out  $clog2(NUM_REQ)  requester that owns the result
//
// Optional feature (macro COMPARATOR_ARBITER_STATS_EN):
//   cnt_eq, cnt_lt, cnt_gt  out 16  saturating counts of accepted results
//   per class, cleared by rst. Without the macro these ports do not exist.
// -----------------------------------------------------------------------------
module comparator_arbiter
  import cmp_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [5:0]                res_flags,
  output logic [ID_W-1:0]           res_id
`ifdef COMPARATOR_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0]         cnt_eq,
  output logic [STAT_W-1:0]         cnt_lt,
  output logic [STAT_W-1:0]         cnt_gt
`endif
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   capt_id_q, capt_id_d;
  logic [DATA_W-1:0] capt_a_q, capt_a_d;
  logic [DATA_W-1:0] capt_b_q, capt_b_d;
  logic              res_valid_q, res_valid_d;
  logic [5:0]        res_flags_q, res_flags_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic              any_valid;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W:0]     idx_ext;
  logic [5:0]        core_flags;

  // Unpack the flat operand buses into per-requester lanes
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
  end

  // Round-robin search: start at rr_q, walk upward with wrap, first valid
  // wins. One extra bit on the index lets the wrap work for any NUM_REQ.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = rr_q;
    idx_ext   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_ext = {1'b0, rr_q} + (ID_W+1)'(k);
      if (idx_ext >= (ID_W+1)'(NUM_REQ)) begin
        idx_ext = idx_ext - (ID_W+1)'(NUM_REQ);
      end
      if (!any_valid && req_valid[idx_ext[ID_W-1:0]]) begin
        any_valid = 1'b1;
        win_idx   = idx_ext[ID_W-1:0];
      end
    end
  end

  cmp_core #(
    .DATA_W (DATA_W)
  ) u_cmp_core (
    .a_i     (capt_a_q),
    .b_i     (capt_b_q),
    .flags_o (core_flags)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = CMP;
      CMP:     state_d = OUT;
      OUT:     if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and datapath next values
  always_comb begin
    req_ready   = '0;
    rr_d        = rr_q;
    capt_id_d   = capt_id_q;
    capt_a_d    = capt_a_q;
    capt_b_d    = capt_b_q;
    res_valid_d = res_valid_q;
    res_flags_d = res_flags_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          // No grant is shown while reset is asserted; the capture below is
          // overridden by reset in the register process anyway.
          req_ready[win_idx] = ~rst;
          capt_id_d          = win_idx;
          capt_a_d           = a_arr[win_idx];
          capt_b_d           = b_arr[win_idx];
          if (win_idx == ID_W'(NUM_REQ - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = win_idx + ID_W'(1);
          end
        end
      end
      CMP: begin
        res_flags_d = core_flags;
        res_id_d    = capt_id_q;
        res_valid_d = 1'b1;
      end
      OUT: begin
        // Flags and id stay as they are after acceptance; only valid drops.
        if (res_ready) res_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      capt_id_q   <= '0;
      capt_a_q    <= '0;
      capt_b_q    <= '0;
      res_valid_q <= 1'b0;
      res_flags_q <= '0;
      res_id_q    <= '0;
    end else begin
      rr_q        <= rr_d;
      capt_id_q   <= capt_id_d;
      capt_a_q    <= capt_a_d;
      capt_b_q    <= capt_b_d;
      res_valid_q <= res_valid_d;
      res_flags_q <= res_flags_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_flags = res_flags_q;
  assign res_id    = res_id_q;

`ifdef COMPARATOR_ARBITER_STATS_EN
  logic              out_done;
  logic [STAT_W-1:0] cnt_eq_q, cnt_lt_q, cnt_gt_q;

  // A result is counted when the consumer takes it, classified by the flag
  // word it carried.
  assign out_done = (state_q == OUT) && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_eq_q <= '0;
      cnt_lt_q <= '0;
      cnt_gt_q <= '0;
    end else if (out_done) begin
      if (res_flags_q[FLG_EQ] && (cnt_eq_q != '1)) cnt_eq_q <= cnt_eq_q + STAT_W'(1);
      if (res_flags_q[FLG_LT] && (cnt_lt_q != '1)) cnt_lt_q <= cnt_lt_q + STAT_W'(1);
      if (res_flags_q[FLG_GT] && (cnt_gt_q != '1)) cnt_gt_q <= cnt_gt_q + STAT_W'(1);
    end
  end

  assign cnt_eq = cnt_eq_q;
  assign cnt_lt = cnt_lt_q;
  assign cnt_gt = cnt_gt_q;
`endif

endmodule

// File: tb/tb_comparator_arbiter.sv
module tb_comparator_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [5:0]     res_flags;
  logic [1:0]     res_id;
`ifdef COMPARATOR_ARBITER_STATS_EN
  logic [15:0]    cnt_eq, cnt_lt, cnt_gt;
`endif

  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = va[i];
      req_b[i*W +: W] = vb[i];
    end
  end

  comparator_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_flags (res_flags),
    .res_id    (res_id)
`ifdef COMPARATOR_ARBITER_STATS_EN
    ,
    .cnt_eq    (cnt_eq),
    .cnt_lt    (cnt_lt),
    .cnt_gt    (cnt_gt)
`endif
  );

  // Reference: unsigned compare straight from the flag table
  function automatic logic [5:0] ref_flags(input logic [3:0] a, input logic [3:0] b);
    if (a == b) return 6'b100011;
    if (a > b)  return 6'b011010;
    return 6'b010101;
  endfunction

  function automatic logic [3:0] pick_operand();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 4'd0;
    if (r == 1) return 4'd15;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    next_cycle();
    rst       = 1'b0;
  endtask

  // Drives one isolated transaction on requester r; returns what was seen.
  task automatic run_txn(input int r, input logic [3:0] a, input logic [3:0] b,
                         output logic [N-1:0] rdy, output int lat,
                         output logic [5:0] fl, output logic [1:0] rid);
    res_ready    = 1'b1;
    va[r]        = a;
    vb[r]        = b;
    req_valid    = '0;
    req_valid[r] = 1'b1;
    #1;
    rdy = req_ready;
    next_cycle();
    req_valid = '0;
    lat = 1;
    #1;
    while (!res_valid && lat < 8) begin
      next_cycle();
      lat++;
      #1;
    end
    fl  = res_flags;
    rid = res_id;
    next_cycle();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      va[i] = pick_operand();
      vb[i] = pick_operand();
    end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      #1;
      checks++;
      if (req_ready !== '0) begin
        failures++;
        $display("FAIL reset_req_ready cycle=%0d got=%b exp=0000", c, req_ready);
      end
      checks++;
      if (res_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_res_valid cycle=%0d got=%b exp=0", c, res_valid);
      end
      checks++;
      if (res_flags !== 6'd0 || res_id !== 2'd0) begin
        failures++;
        $display("FAIL reset_res_data cycle=%0d flags=%b id=%0d exp flags=000000 id=0",
                 c, res_flags, res_id);
      end
    end
`ifdef COMPARATOR_ARBITER_STATS_EN
    checks++;
    if (cnt_eq !== 16'd0 || cnt_lt !== 16'd0 || cnt_gt !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters eq=%0d lt=%0d gt=%0d exp all 0", cnt_eq, cnt_lt, cnt_gt);
    end
`endif
    req_valid = '0;
    rst       = 1'b0;
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single();
    do_reset();
    res_ready = 1'b1;
    va[2] = 4'd5;
    vb[2] = 4'd9;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant got=%b exp=0100", req_ready);
    end
    next_cycle();
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_cmp_cycle ready=%b res_valid=%b exp 0000/0", req_ready, res_valid);
    end
    next_cycle();
    #1;
    checks++;
    if (res_valid !== 1'b1 || res_flags !== 6'b010101 || res_id !== 2'd2) begin
      failures++;
      $display("FAIL single_result valid=%b flags=%b id=%0d exp 1/010101/2",
               res_valid, res_flags, res_id);
    end
    next_cycle();
    #1;
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_release res_valid=%b exp=0", res_valid);
    end
    $display("test_single A=5 B=9 id=2 flags=%b", res_flags);
  endtask

  task automatic test_extremes();
    logic [3:0] ta [4];
    logic [3:0] tb_ [4];
    logic [5:0] te [4];
    logic [N-1:0] rdy;
    int lat;
    logic [5:0] fl;
    logic [1:0] rid;
    ta[0] = 4'd7;  tb_[0] = 4'd7;  te[0] = 6'b100011;
    ta[1] = 4'd15; tb_[1] = 4'd0;  te[1] = 6'b011010;
    ta[2] = 4'd0;  tb_[2] = 4'd15; te[2] = 6'b010101;
    ta[3] = 4'd0;  tb_[3] = 4'd0;  te[3] = 6'b100011;
    for (int k = 0; k < 4; k++) begin
      run_txn(k, ta[k], tb_[k], rdy, lat, fl, rid);
      checks++;
      if (rdy !== N'(1 << k) || lat != 2) begin
        failures++;
        $display("FAIL extreme_grant k=%0d ready=%b latency=%0d exp ready=%b latency=2",
                 k, rdy, lat, N'(1 << k));
      end
      checks++;
      if (fl !== te[k] || rid !== 2'(k)) begin
        failures++;
        $display("FAIL extreme_flags A=%0d B=%0d flags=%b id=%0d exp %b/%0d",
                 ta[k], tb_[k], fl, rid, te[k], k);
      end
      $display("test_extremes A=%0d B=%0d flags=%b id=%0d", ta[k], tb_[k], fl, rid);
    end
  endtask

  task automatic test_round_robin();
    int g_cyc [$];
    logic [N-1:0] g_vec [$];
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      va[i] = pick_operand();
      vb[i] = pick_operand();
    end
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (req_ready !== '0) begin
        g_cyc.push_back(c);
        g_vec.push_back(req_ready);
      end
      next_cycle();
    end
    req_valid = '0;
    checks++;
    if (g_cyc.size() < 5) begin
      failures++;
      $display("FAIL rr_grant_count got=%0d exp>=5", g_cyc.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (g_vec[k] !== N'(1 << (k % N))) begin
          failures++;
          $display("FAIL rr_order grant=%0d got=%b exp=%b", k, g_vec[k], N'(1 << (k % N)));
        end
        if (k > 0) begin
          checks++;
          if (g_cyc[k] - g_cyc[k-1] != 3) begin
            failures++;
            $display("FAIL rr_spacing grant=%0d got=%0d exp=3", k, g_cyc[k] - g_cyc[k-1]);
          end
        end
        $display("test_round_robin grant=%0d cycle=%0d ready=%b", k, g_cyc[k], g_vec[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    res_ready = 1'b0;
    va[1] = 4'd3;
    vb[1] = 4'd3;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_grant got=%b exp=0010", req_ready);
    end
    next_cycle();
    req_valid = '1;
    n = 0;
    #1;
    while (!res_valid && n < 8) begin
      next_cycle();
      n++;
      #1;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (res_valid !== 1'b1 || res_flags !== 6'b100011 || res_id !== 2'd1 || req_ready !== '0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d valid=%b flags=%b id=%0d ready=%b exp 1/100011/1/0000",
                 c, res_valid, res_flags, res_id, req_ready);
      end
      next_cycle();
      #1;
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b1 || req_ready !== '0) begin
      failures++;
      $display("FAIL bp_accept_cycle valid=%b ready=%b exp 1/0000", res_valid, req_ready);
    end
    next_cycle();
    #1;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_after_accept valid=%b ready=%b exp 0/0100", res_valid, req_ready);
    end
    req_valid = '0;
    $display("test_backpressure held 5 cycles, next grant ready=%b", req_ready);
  endtask

  task automatic test_midop_reset();
    logic [N-1:0] rdy;
    int lat;
    logic [5:0] fl;
    logic [1:0] rid;
    do_reset();
    // One finished transaction moves the pointer away from 0 and bumps a counter
    run_txn(2, 4'd9, 4'd4, rdy, lat, fl, rid);
    req_valid = 4'b1000;
    va[3] = 4'd1;
    vb[3] = 4'd2;
    next_cycle();          // grant edge: now in the compare cycle
    req_valid = '0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (res_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_no_result cycle=%0d res_valid=%b exp=0", c, res_valid);
      end
      next_cycle();
    end
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_restart ready=%b exp=0001", req_ready);
    end
`ifdef COMPARATOR_ARBITER_STATS_EN
    checks++;
    if (cnt_eq !== 16'd0 || cnt_lt !== 16'd0 || cnt_gt !== 16'd0) begin
      failures++;
      $display("FAIL midrst_counters eq=%0d lt=%0d gt=%0d exp all 0", cnt_eq, cnt_lt, cnt_gt);
    end
`endif
    req_valid = '0;
    $display("test_midop_reset restart ready=%b", req_ready);
  endtask

  task automatic test_random(input int ncyc);
    int rr_m, valid_from, exp_id, granted, w;
    bit idle_m, exp_rv;
    logic [N-1:0] exp_rdy;
    logic [5:0] exp_fl;
    int n_eq, n_lt, n_gt, n_res;
    do_reset();
    rr_m = 0; idle_m = 1'b1; valid_from = 0; exp_id = 0; exp_fl = '0; granted = -1;
    n_eq = 0; n_lt = 0; n_gt = 0; n_res = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (granted >= 0) req_valid[granted] = 1'b0;
      granted = -1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          va[i] = pick_operand();
          vb[i] = pick_operand();
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = '0;
      w = -1;
      if (idle_m) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (rr_m + k) % N;
          if (w < 0 && req_valid[idx]) w = idx;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      exp_rv = !idle_m && (cyc >= valid_from);
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rand_ready cycle=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
      end
      checks++;
      if (res_valid !== exp_rv) begin
        failures++;
        $display("FAIL rand_res_valid cycle=%0d got=%b exp=%b", cyc, res_valid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (res_flags !== exp_fl || res_id !== 2'(exp_id)) begin
          failures++;
          $display("FAIL rand_result cycle=%0d flags=%b id=%0d exp %b/%0d",
                   cyc, res_flags, res_id, exp_fl, exp_id);
        end
      end
      if (w >= 0) begin
        idle_m     = 1'b0;
        valid_from = cyc + 2;
        exp_fl     = ref_flags(va[w], vb[w]);
        exp_id     = w;
        rr_m       = (w + 1) % N;
        granted    = w;
      end else if (exp_rv && res_ready) begin
        idle_m = 1'b1;
        n_res++;
        if (exp_fl == 6'b100011) n_eq++;
        else if (exp_fl == 6'b010101) n_lt++;
        else n_gt++;
      end
      next_cycle();
    end
    req_valid = '0;
`ifdef COMPARATOR_ARBITER_STATS_EN
    checks++;
    if (cnt_eq !== 16'(n_eq) || cnt_lt !== 16'(n_lt) || cnt_gt !== 16'(n_gt)) begin
      failures++;
      $display("FAIL rand_counters eq=%0d lt=%0d gt=%0d exp %0d/%0d/%0d",
               cnt_eq, cnt_lt, cnt_gt, n_eq, n_lt, n_gt);
    end
`endif
    $display("test_random cycles=%0d results=%0d eq=%0d lt=%0d gt=%0d", ncyc, n_res, n_eq, n_lt, n_gt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      va[i] = '0;
      vb[i] = '0;
    end
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_midop_reset();
    test_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
